// File: rtl/module_count_controller_pkg.sv
// Shared definitions for the counter sequencing controller: default width,
// FSM state encoding and small decode helpers.
package module_count_controller_pkg;

  localparam int WIDTH_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_busy(input state_e st);
    return (st == ST_RUN) || (st == ST_PAUSE);
  endfunction

endpackage

// File: rtl/module_count_controller_if.sv
// Control/status bundle between the user-side driver and the count controller.
interface module_count_controller_if #(parameter int WIDTH = 7);

  logic             start;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, hold, abort, limit,
    input  count, busy, done, state
  );

  modport slave (
    input  start, hold, abort, limit,
    output count, busy, done, state
  );

endinterface

// File: rtl/module_count_controller_core.sv
// WIDTH-bit synchronous counter built from T flip-flops and a 2-input AND
// carry chain; a synchronous clear toggles every bit that is currently set.
module modulo_ff_t (
  input  logic clk,
  input  logic clr,
  input  logic t,
  output logic q
);

  logic q_r;

  // Toggle storage with asynchronous active-low clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_r <= 1'b0;
    end else if (t) begin
      q_r <= ~q_r;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

module and_gate_2_inputs (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

module module_count_core #(parameter int WIDTH = 7) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] carry_s;
  logic [WIDTH-1:0] t_s;

  assign carry_s[0] = en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < WIDTH - 1) begin : g_chain
      and_gate_2_inputs u_and (
        .a (carry_s[i]),
        .b (q[i]),
        .y (carry_s[i+1])
      );
    end

    // Clearing a set bit means toggling it once; clear overrides counting
    assign t_s[i] = sync_clr ? q[i] : carry_s[i];

    modulo_ff_t u_ff (
      .clk (clk),
      .clr (clr),
      .t   (t_s[i]),
      .q   (q[i])
    );
  end

endmodule

// File: rtl/module_count_controller.sv
// Sequencing controller: owns the FSM, latched terminal value, comparator and
// done pulse, and is the sole source of enable/clear for the counter core.
module module_count_controller
  import module_count_controller_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     clr,
  module_count_controller_if.slave bus
);

  state_e           state_r;
  state_e           state_nx_s;
  logic [WIDTH-1:0] limit_q_r;
  logic [WIDTH-1:0] count_s;
  logic             done_r;
  logic             en_s;
  logic             sync_clr_s;
  logic             latch_s;
  logic             at_limit_s;

  assign at_limit_s = (count_s == limit_q_r);

  // Next-state and core control; abort outranks start, start outranks hold/terminal
  always_comb begin
    state_nx_s = state_r;
    en_s       = 1'b0;
    sync_clr_s = 1'b0;
    latch_s    = 1'b0;
    if (bus.abort) begin
      state_nx_s = ST_IDLE;
      sync_clr_s = 1'b1;
    end else if (bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
      state_nx_s = ST_RUN;
      sync_clr_s = 1'b1;
      latch_s    = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.hold) begin
            state_nx_s = ST_PAUSE;
          end else if (at_limit_s) begin
            state_nx_s = ST_DONE;
          end else begin
            en_s = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!bus.hold) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_PAUSE;
          end
        end
        ST_IDLE:  state_nx_s = ST_IDLE;
        ST_DONE:  state_nx_s = ST_DONE;
        default:  state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State, terminal value and done pulse registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r   <= ST_IDLE;
      limit_q_r <= {WIDTH{1'b0}};
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      limit_q_r <= latch_s ? bus.limit : limit_q_r;
      done_r    <= (state_r == ST_RUN) && (state_nx_s == ST_DONE);
    end
  end

  module_count_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .clr      (clr),
    .en       (en_s),
    .sync_clr (sync_clr_s),
    .q        (count_s)
  );

  assign bus.count = count_s;
  assign bus.busy  = is_busy(state_r);
  assign bus.done  = done_r;
  assign bus.state = state_r;

endmodule

// File: doc/module_count_controller.md
# module_count_controller

Sequencing controller for the 7-bit T-flip-flop counter chain. Starts, pauses, resumes and aborts a count run, latches a programmable terminal value, stops the count on reaching it, and reports busy/done status. Sits between the user control inputs (buttons/switches) and the counter core; it owns the only enable and clear of that core.

## Interface

Parameters:
- WIDTH, 7, counter width in bits.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  synchronous start request, sampled each cycle.
- hold  in  1  level pause request; high freezes the count.
- abort  in  1  synchronous abort; returns to IDLE and zeroes the count.
- limit  in  WIDTH  terminal count, latched on an accepted start.
- count  out  WIDTH  current counter value.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  one-cycle pulse on the first cycle in DONE.
- state  out  2  encoded FSM state, for display/debug.

## Operation

- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Priority each cycle: clr (async) > abort > start > hold/terminal logic.
- abort=1, any state: next state IDLE, count←0, limit_q unchanged.
- IDLE or DONE, start=1: next state RUN, count←0, limit_q←limit.
- RUN or PAUSE, start=1: ignored; no relatch, no count reset.
- RUN, hold=1: next state PAUSE, count unchanged.
- RUN, hold=0, count==limit_q: next state DONE, count unchanged.
- RUN, hold=0, count!=limit_q: count←count+1, stays in RUN.
- PAUSE, hold=0: next state RUN, count unchanged that cycle. PAUSE, hold=1: stay.
- DONE: stays until start or abort; count holds the terminal value.
- Arithmetic: count is unsigned WIDTH bits, limit_q ≤ 2^WIDTH−1, so count never wraps inside a run.
- limit=0: run lasts one RUN cycle at count=0, then DONE.
- Changing limit during a run has no effect; only limit_q is compared.

## Timing

- Reset values: state=IDLE, count=0, limit_q=0, busy=0, done=0.
- All outputs registered or decoded from registered state; no combinational input-to-output path.
- start accepted at edge N → state=RUN, count=0 after edge N.
- Run of limit L without hold: RUN for L+1 cycles (count 0..L), DONE entered on the edge after count==L is sampled.
- done high for exactly one cycle, coincident with the first DONE cycle. A start in that same cycle is accepted; done still pulses.
- hold has one-cycle latency: increment at edge N is suppressed only if hold=1 was sampled at edge N.
- clr deassertion is asynchronous to clk; the first state change occurs at the first rising edge with clr=1.
- clr asserted mid-run: all outputs return to reset values immediately, with no clock required.

## Structure

- Shared package: WIDTH default, state encoding constants (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE).
- One sub-module: module_count_core, a WIDTH-bit counter with clk, clr, synchronous en and sync_clr, and output q. Built from modulo_ff_t T flip-flops with an and_gate_2_inputs carry chain; sync_clr is realised by toggling the set bits.
- The controller holds the FSM, limit_q, the comparator and the done pulse register. It drives core en = (state==RUN & !hold & count!=limit_q) and sync_clr = (abort | accepted start).

## Test plan

- Reset: clr=0 mid-run at count=37 → count=0, state=IDLE, busy=0 immediately. After release, no activity until start.
- Basic run: limit=5, start pulse → count 0,1,2,3,4,5 in RUN, then DONE. done=1 for one cycle, count holds 5, busy falls the same edge.
- Pause: limit=10, hold=1 for 3 cycles at count=4 → PAUSE; count stays 4 for 3 cycles, then resumes 5..10 → DONE.
- Abort and priorities: abort at count=6 → IDLE, count=0. start+abort in the same cycle → IDLE. start during RUN → ignored. limit changed mid-run 5→2 → run still ends at 5.
- Boundaries: limit=0 → one RUN cycle, then DONE. limit=127 → 128 RUN cycles, no wrap, count=127 in DONE.
- Restart from DONE: start in the DONE cycle with limit=3 → done pulses once, next state RUN, count=0, new limit_q=3.
